// File: rtl/uart_ahb_master.sv
// Serial debug bridge: UART command frames in, single-word AHB transfers out,
// status byte (plus read data) back over UART. Contains the small uart core it
// uses for bit timing, followed by the bridge top.

// uart core: fractional-baud tick generator, 16x oversampled receiver and
// transmitter, 8N1, LSB first on the wire.
module uart_core (
  input  logic        CLK_I,
  input  logic        RST_N_I,
  input  logic [10:0] ADD_I,
  input  logic        RX_I,
  output logic        TX_O,
  input  logic        TX_VALID_I,
  input  logic [7:0]  TX_DATA_I,
  output logic        TX_BUSY_O,
  output logic        RX_VALID_O,
  output logic [7:0]  RX_DATA_O,
  output logic        RX_ERR_O
);
  logic [11:0] acc;
  logic        tick;
  logic [2:0]  rx_sync;
  logic        rx_busy;
  logic [3:0]  rx_tcnt;
  logic [3:0]  rx_bcnt;
  logic [7:0]  rx_sh;
  logic [9:0]  tx_sh;
  logic [3:0]  tx_tcnt;
  logic [3:0]  tx_bcnt;

  // Phase accumulator: carry-out is the 16x oversampling tick
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) {tick, acc} <= 13'd0;
    else          {tick, acc} <= {1'b0, acc} + {2'b00, ADD_I};
  end

  // Receiver: start on a falling edge, sample each bit at its middle tick
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      rx_sync    <= 3'b111;
      rx_busy    <= 1'b0;
      rx_tcnt    <= 4'd0;
      rx_bcnt    <= 4'd0;
      rx_sh      <= 8'd0;
      RX_VALID_O <= 1'b0;
      RX_DATA_O  <= 8'd0;
      RX_ERR_O   <= 1'b0;
    end else begin
      rx_sync    <= {rx_sync[1:0], RX_I};
      RX_VALID_O <= 1'b0;
      RX_ERR_O   <= 1'b0;
      if (!rx_busy) begin
        // edge-triggered start so a low stop bit cannot re-trigger a frame
        if (rx_sync[2] && !rx_sync[1]) begin
          rx_busy <= 1'b1;
          rx_tcnt <= 4'd0;
          rx_bcnt <= 4'd0;
        end
      end else if (tick) begin
        rx_tcnt <= rx_tcnt + 4'd1;
        if (rx_tcnt == 4'd7) begin
          if (rx_bcnt == 4'd0) begin
            if (rx_sync[1]) rx_busy <= 1'b0;
            else            rx_bcnt <= 4'd1;
          end else if (rx_bcnt == 4'd9) begin
            rx_busy <= 1'b0;
            if (rx_sync[1]) begin
              RX_VALID_O <= 1'b1;
              RX_DATA_O  <= rx_sh;
            end else begin
              RX_ERR_O <= 1'b1;
            end
          end else begin
            rx_sh   <= {rx_sync[1], rx_sh[7:1]};
            rx_bcnt <= rx_bcnt + 4'd1;
          end
        end
      end
    end
  end

  // Transmitter: shift {stop, data, start} out, one bit per 16 ticks
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      tx_sh     <= 10'h3FF;
      tx_tcnt   <= 4'd0;
      tx_bcnt   <= 4'd0;
      TX_BUSY_O <= 1'b0;
    end else if (!TX_BUSY_O) begin
      if (TX_VALID_I) begin
        tx_sh     <= {1'b1, TX_DATA_I, 1'b0};
        tx_tcnt   <= 4'd0;
        tx_bcnt   <= 4'd0;
        TX_BUSY_O <= 1'b1;
      end
    end else if (tick) begin
      tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_tcnt == 4'd15) begin
        tx_sh <= {1'b1, tx_sh[9:1]};
        if (tx_bcnt == 4'd9) TX_BUSY_O <= 1'b0;
        else                 tx_bcnt   <= tx_bcnt + 4'd1;
      end
    end
  end

  assign TX_O = tx_sh[0];
endmodule

// Bridge top: command FSM driving the AHB master interface
module uart_ahb_master #(
  parameter logic [10:0] CLK_ADD = 11'd629,
  parameter logic [31:0] TIMEOUT = 32'd50000000
) (
  input  logic        HCLK_I,
  input  logic        HRESET_N_I,
  input  logic        RX_I,
  output logic        TX_O,
  output logic        BUSY_O,
  output logic [31:0] HADDR_O,
  output logic [1:0]  HTRANS_O,
  output logic        HWRITE_O,
  output logic [2:0]  HSIZE_O,
  output logic [31:0] HWDATA_O,
  input  logic [31:0] HRDATA_I,
  input  logic        HREADY_I,
  input  logic        HRESP_I
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_ADDR  = 3'd1;
  localparam logic [2:0] S_GET_DATA  = 3'd2;
  localparam logic [2:0] S_BUS_ADDR  = 3'd3;
  localparam logic [2:0] S_BUS_DATA  = 3'd4;
  localparam logic [2:0] S_SEND_HDR  = 3'd5;
  localparam logic [2:0] S_SEND_DATA = 3'd6;

  logic [2:0]  state;
  logic        is_wr;
  logic        nak;
  logic [2:0]  byte_cnt;
  logic [31:0] timer;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx_pulse;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic        rx_valid;
  logic        rx_err;
  logic [7:0]  rx_data;

  uart_core u_uart (
    .CLK_I      (HCLK_I),
    .RST_N_I    (HRESET_N_I),
    .ADD_I      (CLK_ADD),
    .RX_I       (RX_I),
    .TX_O       (TX_O),
    .TX_VALID_I (tx_pulse),
    .TX_DATA_I  (tx_byte),
    .TX_BUSY_O  (tx_busy),
    .RX_VALID_O (rx_valid),
    .RX_DATA_O  (rx_data),
    .RX_ERR_O   (rx_err)
  );

  assign HSIZE_O = 3'b010;
  assign BUSY_O  = (state != S_IDLE);

  // Command FSM: frame capture, AHB transfer, response transmission
  always_ff @(posedge HCLK_I or negedge HRESET_N_I) begin
    if (!HRESET_N_I) begin
      state    <= S_IDLE;
      is_wr    <= 1'b0;
      nak      <= 1'b0;
      byte_cnt <= 3'd0;
      timer    <= 32'd0;
      addr     <= 32'd0;
      wdata    <= 32'd0;
      rdata    <= 32'd0;
      tx_pulse <= 1'b0;
      tx_byte  <= 8'd0;
      HADDR_O  <= 32'd0;
      HTRANS_O <= 2'b00;
      HWRITE_O <= 1'b0;
      HWDATA_O <= 32'd0;
    end else begin
      tx_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_err) begin
            nak   <= 1'b1;
            state <= S_SEND_HDR;
          end else if (rx_valid) begin
            if (rx_data == 8'h52 || rx_data == 8'h57) begin
              is_wr    <= (rx_data == 8'h57);
              nak      <= 1'b0;
              byte_cnt <= 3'd0;
              timer    <= 32'd0;
              state    <= S_GET_ADDR;
            end else begin
              nak   <= 1'b1;
              state <= S_SEND_HDR;
            end
          end
        end
        S_GET_ADDR, S_GET_DATA: begin
          if (rx_err) begin
            nak   <= 1'b1;
            state <= S_SEND_HDR;
          end else if (rx_valid) begin
            timer    <= 32'd0;
            byte_cnt <= byte_cnt + 3'd1;
            if (state == S_GET_ADDR) addr  <= {addr[23:0], rx_data};
            else                     wdata <= {wdata[23:0], rx_data};
            if (byte_cnt == 3'd3) begin
              byte_cnt <= 3'd0;
              if (state == S_GET_ADDR && is_wr) begin
                state <= S_GET_DATA;
              end else begin
                // address phase starts on the cycle right after the last byte
                state    <= S_BUS_ADDR;
                HTRANS_O <= 2'b10;
                HWRITE_O <= is_wr;
                HADDR_O  <= (state == S_GET_ADDR) ? {addr[23:0], rx_data[7:2], 2'b00}
                                                  : {addr[31:2], 2'b00};
              end
            end
          end else if (timer >= TIMEOUT - 32'd1) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        S_BUS_ADDR: begin
          if (HREADY_I) begin
            HTRANS_O <= 2'b00;
            HWDATA_O <= wdata;
            state    <= S_BUS_DATA;
          end
        end
        S_BUS_DATA: begin
          if (HREADY_I) begin
            rdata    <= HRDATA_I;
            nak      <= HRESP_I;
            HWRITE_O <= 1'b0;
            state    <= S_SEND_HDR;
          end
        end
        S_SEND_HDR: begin
          // one-cycle gap after a pulse lets the core's busy flag rise
          if (!tx_busy && !tx_pulse) begin
            tx_pulse <= 1'b1;
            tx_byte  <= nak ? 8'h15 : 8'h06;
            byte_cnt <= 3'd0;
            state    <= (!is_wr && !nak) ? S_SEND_DATA : S_IDLE;
          end
        end
        S_SEND_DATA: begin
          if (!tx_busy && !tx_pulse) begin
            tx_pulse <= 1'b1;
            tx_byte  <= rdata[31:24];
            rdata    <= {rdata[23:0], 8'h00};
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd3) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_ahb_master.md
Name: uart_ahb_master

Overview:
- Serial debug bridge. It receives framed commands on a UART line and issues single-word AHB read/write transfers as bus initiator.
- It returns a status byte, and for reads the data, over the UART transmit line.
- It instantiates the existing uart core for bit timing and drives the system AHB as a master, so a host PC can poke peripherals such as ahb_uart.

Parameters:
- CLK_ADD, 11'd629, baud increment driven onto the uart core ADD_I (fixed, not programmable).
- TIMEOUT, 32'd50000000, maximum HCLK cycles allowed between received bytes inside a frame.

Ports:
- HCLK_I  in  1  system clock; the only clock.
- HRESET_N_I  in  1  asynchronous active-low reset.
- RX_I  in  1  serial receive line.
- TX_O  out  1  serial transmit line.
- BUSY_O  out  1  high whenever the FSM is not in IDLE.
- HADDR_O  out  32  AHB address; bits [1:0] always 0.
- HTRANS_O  out  2  2'b10 (NONSEQ) during the address phase, else 2'b00 (IDLE).
- HWRITE_O  out  1  transfer direction, valid with HTRANS_O.
- HSIZE_O  out  3  constant 3'b010 (word).
- HWDATA_O  out  32  write data, driven during the data phase.
- HRDATA_I  in  32  read data from the slave.
- HREADY_I  in  1  slave ready / transfer completion.
- HRESP_I  in  1  slave error response (1 = ERROR).

Behaviour:
- Reset values (asynchronous, HRESET_N_I low): FSM = IDLE, HTRANS_O = 0, HWRITE_O = 0, HADDR_O = 0, HWDATA_O = 0, BUSY_O = 0, all byte/shift counters = 0. TX_O idles high (inside the uart core).
- Reset mid-frame or mid-transfer aborts immediately; no response byte is sent.
- Frame format, bytes MSB first:
  - Read: 0x52 'R', A3, A2, A1, A0.
  - Write: 0x57 'W', A3, A2, A1, A0, D3, D2, D1, D0.
- Responses:
  - 0x06 (ACK); reads follow the ACK with D3..D0 of the captured HRDATA_I.
  - 0x15 (NAK) on HRESP_I error, unknown command byte, or uart RX error.
- FSM states: IDLE, GET_ADDR, GET_DATA, BUS_ADDR, BUS_DATA, SEND_HDR, SEND_DATA.
- IDLE:
  - RX byte 0x52 or 0x57 -> GET_ADDR; latch direction, clear byte counter.
  - Any other byte -> SEND_HDR with NAK.
- GET_ADDR: shift 4 bytes into the address register.
  - After the 4th byte: write -> GET_DATA, read -> BUS_ADDR.
- GET_DATA: shift 4 bytes into the write-data register, then -> BUS_ADDR.
- Inter-byte timeout: in GET_ADDR/GET_DATA, a counter resets on each RX byte. Reaching TIMEOUT -> IDLE silently, frame discarded.
- RX error pulse: in any receive state (including IDLE) -> SEND_HDR with NAK. It is ignored in bus and send states.
- BUS_ADDR:
  - Drive HTRANS_O = NONSEQ, HADDR_O = {addr[31:2], 2'b00}, HWRITE_O = direction.
  - Hold until a cycle with HREADY_I = 1, then -> BUS_DATA with HTRANS_O = IDLE from the next cycle.
- BUS_DATA:
  - HWDATA_O holds write data for the whole state.
  - On HREADY_I = 1: capture HRDATA_I (reads), then -> SEND_HDR.
  - Response is ACK, or NAK if HRESP_I = 1 in that cycle.
  - Wait states (HREADY_I = 0) are unlimited.
- Transmit handshake:
  - Pulse uart TX_VALID_I for exactly one cycle only when TX_BUSY_O = 0 and no pulse was issued in the previous cycle.
  - Advance the byte counter on each pulse.
- SEND_HDR:
  - After the header pulse: read with ACK -> SEND_DATA; otherwise -> IDLE.
- SEND_DATA: send D3..D0, then -> IDLE.
- RX bytes arriving outside the receive states are dropped.
- Worst-case bus latency: first NONSEQ cycle is 1 HCLK after the last frame byte is received.

Test Plan:
- Write: RX 57 00 00 10 08 DE AD BE EF, slave zero-wait -> one NONSEQ cycle with HADDR_O = 0x00001008, HWRITE_O = 1; HWDATA_O = 0xDEADBEEF in data phase; TX byte 0x06; BUSY_O low afterwards.
- Read: RX 52 00 00 20 03, slave returns 0x12345678 after 3 wait states -> HADDR_O = 0x00002000 (low bits forced 0); TX 06 12 34 56 78 in order.
- Error response: read with HRESP_I = 1 on the completing data-phase cycle -> TX 0x15 only, FSM returns to IDLE.
- Bad command / RX error: RX byte 0x41 -> TX 0x15. Corrupted stop bit mid-address -> TX 0x15, no AHB transfer.
- Timeout: TIMEOUT = 1000; send 52 00 00, then idle 1200 cycles -> no TX, no NONSEQ. A following complete read frame executes normally.
- Async reset: assert HRESET_N_I during BUS_DATA wait states -> HTRANS_O = 0 and BUSY_O = 0 without a clock edge; no response byte after release.
